// File: rtl/step_rate_decoder_if.sv
// Pin bundle for the step-rate decoder tile: 8 input pins in, 8 status pins out.
interface step_rate_decoder_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave (input io_in, output io_out);
endinterface

// File: rtl/step_rate_decoder.sv
// Step-rate decoder: measures the interval between rising edges of an incoming
// step stream, recovers its 3-bit speed code and reports lock/stall/error.
module step_rate_decoder #(
  parameter int BASE     = 4,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 3
) (
  step_rate_decoder_if.slave bus
);
  localparam int CW = BASE + 8;
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] TIMEOUT = CW'((1 << (BASE + 7)) + TOL + 1);

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  logic clk, rst_n, step, unused_pins;
  assign clk         = bus.io_in[0];
  assign rst_n       = bus.io_in[1];
  assign step        = bus.io_in[2];
  assign unused_pins = ^bus.io_in[7:3];

  logic          sync1, sync2, prev, edge_det;
  logic [CW-1:0] cnt;

  // The counter holds the clocks elapsed since the last edge, so at the next edge it equals the interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= step;
      sync2 <= sync1;
      prev  <= sync2;
      if (edge_det)
        cnt <= CW'(1);
      else if (cnt != '1)
        cnt <= cnt + CW'(1);
    end
  end

  assign edge_det = sync2 & ~prev;

  logic [31:0] interval;
  logic        code_valid;
  logic [2:0]  code;
  assign interval = 32'(cnt);

  always_comb begin
    code_valid = 1'b0;
    code       = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (interval >= 32'((1 << (BASE + k)) - TOL) &&
          interval <= 32'((1 << (BASE + k)) + TOL)) begin
        code_valid = 1'b1;
        code       = 3'(k);
      end
    end
  end

  state_t         state;
  logic [2:0]     cand, speed;
  logic [MW-1:0]  match_cnt, match_next;
  logic           locked, stalled, err, edge_q, activity, timeout;

  assign match_next = (code == cand) ? match_cnt + MW'(1) : MW'(1);
  assign timeout    = (state != IDLE) && !edge_det && (cnt == TIMEOUT);

  // An edge always takes priority over a timeout landing on the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= 3'd0;
      speed     <= 3'd0;
      match_cnt <= '0;
      locked    <= 1'b0;
      stalled   <= 1'b0;
      err       <= 1'b0;
      edge_q    <= 1'b0;
      activity  <= 1'b0;
    end else begin
      edge_q <= edge_det;
      if (edge_det) begin
        activity <= ~activity;
        case (state)
          IDLE: begin
            stalled <= 1'b0;
            state   <= MEASURE;
          end
          MEASURE: begin
            if (!code_valid) begin
              match_cnt <= '0;
            end else begin
              cand      <= code;
              match_cnt <= match_next;
              if (match_next == MW'(LOCK_CNT)) begin
                locked <= 1'b1;
                speed  <= code;
                err    <= 1'b0;
                state  <= LOCKED;
              end
            end
          end
          LOCKED: begin
            if (!code_valid) begin
              err       <= 1'b1;
              locked    <= 1'b0;
              match_cnt <= '0;
              state     <= MEASURE;
            end else if (code != speed) begin
              locked    <= 1'b0;
              cand      <= code;
              match_cnt <= MW'(1);
              state     <= MEASURE;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (timeout) begin
        stalled   <= 1'b1;
        locked    <= 1'b0;
        match_cnt <= '0;
        state     <= IDLE;
      end
    end
  end

  assign bus.io_out = {activity, edge_q, err, stalled, locked, speed};
endmodule

// File: tb/tb_step_rate_decoder.sv
// Bench for step_rate_decoder: hand-derived vector tables and sequences plus
// randomized step streams checked every cycle against an edge-timestamp model.
module tb_step_rate_decoder;
  localparam int BASE     = 4;
  localparam int TOL      = 1;
  localparam int LOCK_CNT = 3;
  localparam int TIMEOUT  = (1 << (BASE + 7)) + TOL + 1;
  localparam int S_IDLE = 0, S_MEAS = 1, S_LOCK = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       step  = 1'b0;
  logic [4:0] junk  = 5'd0;

  step_rate_decoder_if bus ();
  assign bus.io_in = {junk, step, rst_n, clk};

  step_rate_decoder #(.BASE(BASE), .TOL(TOL), .LOCK_CNT(LOCK_CNT)) dut (.bus(bus));

  initial forever #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: works from rising-edge timestamps and the classification rule.
  int     m_state, m_cand, m_match, m_speed;
  bit     m_locked, m_stalled, m_err, m_edge, m_act;
  longint cyc, last_edge;
  bit     prev_s, rise_d1, rise_d2;

  function automatic int classify(input longint iv);
    longint d;
    for (int k = 0; k < 8; k++) begin
      d = iv - (longint'(1) << (BASE + k));
      if (d <= TOL && d >= -TOL) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_cand = 0; m_match = 0; m_speed = 0;
    m_locked = 0; m_stalled = 0; m_err = 0; m_edge = 0; m_act = 0;
    cyc = 0; last_edge = 0; prev_s = 0; rise_d1 = 0; rise_d2 = 0;
  endtask

  task automatic model_clock(input logic s);
    bit     ev;
    longint iv;
    int     k;
    if (!rst_n) begin
      model_reset();
      return;
    end
    cyc++;
    ev      = rise_d2;
    rise_d2 = rise_d1;
    rise_d1 = s & ~prev_s;
    prev_s  = s;
    m_edge  = ev;
    if (ev) begin
      m_act     = ~m_act;
      iv        = cyc - last_edge;
      last_edge = cyc;
      if (m_state == S_IDLE) begin
        m_stalled = 0;
        m_state   = S_MEAS;
      end else begin
        k = classify(iv);
        if (m_state == S_LOCK) begin
          if (k < 0) begin
            m_err = 1; m_locked = 0; m_match = 0; m_state = S_MEAS;
          end else if (k != m_speed) begin
            m_locked = 0; m_cand = k; m_match = 1; m_state = S_MEAS;
          end
        end else if (k < 0) begin
          m_match = 0;
        end else begin
          m_match = (k == m_cand) ? m_match + 1 : 1;
          m_cand  = k;
          if (m_match == LOCK_CNT) begin
            m_locked = 1; m_speed = k; m_err = 0; m_state = S_LOCK;
          end
        end
      end
    end else if (m_state != S_IDLE && (cyc - last_edge) == TIMEOUT) begin
      m_stalled = 1; m_locked = 0; m_match = 0; m_state = S_IDLE;
    end
  endtask

  function automatic logic [7:0] model_out();
    return {m_act, m_edge, m_err, m_stalled, m_locked, 3'(m_speed)};
  endfunction

  task automatic check_output(input string name, input logic [7:0] got, input logic [7:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s: io_out=%02h expected=%02h at %0t", name, got, want, $time);
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, compare at the next falling edge.
  task automatic apply_stimulus(input logic s);
    step = s;
    junk = 5'($urandom);
    @(posedge clk);
    model_clock(s);
    @(negedge clk);
    check_output("model", bus.io_out, model_out());
  endtask

  task automatic step_pulse(input int gap);
    apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    for (int i = 2; i < gap; i++) apply_stimulus(1'b0);
  endtask

  task automatic async_reset_pulse();
    #1 rst_n = 1'b0;
    #2 check_output("async reset", bus.io_out, 8'h00);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    int         gap;
    logic [7:0] want;
  } row_t;
  row_t rows[15];

  int longs, code, run, kind, gap;

  initial begin
    rows[0]  = '{17,   8'h80};
    rows[1]  = '{15,   8'h00};
    rows[2]  = '{18,   8'h80};
    rows[3]  = '{16,   8'h00};
    rows[4]  = '{16,   8'h80};
    rows[5]  = '{17,   8'h00};
    rows[6]  = '{40,   8'h88};
    rows[7]  = '{16,   8'h20};
    rows[8]  = '{2100, 8'hB0};
    rows[9]  = '{16,   8'h20};
    rows[10] = '{16,   8'hA0};
    rows[11] = '{16,   8'h20};
    rows[12] = '{16,   8'h88};
    rows[13] = '{2050, 8'h08};
    rows[14] = '{16,   8'hA0};

    model_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(logic'(i[0]));
      check_output("reset hold", bus.io_out, 8'h00);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0);
      check_output("post reset idle", bus.io_out, 8'h00);
    end

    // Tolerance windows, invalid-interval restart, error, stall and edge-vs-timeout.
    for (int r = 0; r < 15; r++) begin
      step_pulse(rows[r].gap);
      check_output($sformatf("table row %0d", r), bus.io_out, rows[r].want);
    end

    rst_n = 1'b0;
    apply_stimulus(1'b0);
    apply_stimulus(1'b0);
    rst_n = 1'b1;

    // Lock at code 3, with the exact output latency around the fourth edge.
    for (int i = 0; i < 3; i++) step_pulse(128);
    apply_stimulus(1'b1);
    check_output("rise sampled", bus.io_out, 8'h80);
    apply_stimulus(1'b1);
    check_output("rise in sync", bus.io_out, 8'h80);
    apply_stimulus(1'b0);
    check_output("lock latency", bus.io_out, 8'h4B);
    apply_stimulus(1'b0);
    check_output("edge one cycle", bus.io_out, 8'h0B);
    for (int i = 4; i < 128; i++) apply_stimulus(1'b0);

    step_pulse(2048);
    check_output("locked code 3", bus.io_out, 8'h8B);
    step_pulse(2048);
    check_output("speed change drop", bus.io_out, 8'h03);
    step_pulse(2048);
    check_output("speed change match2", bus.io_out, 8'h83);
    step_pulse(300);
    check_output("relock code 7", bus.io_out, 8'h0F);

    async_reset_pulse();
    step_pulse(256);
    check_output("resync first edge", bus.io_out, 8'h80);
    for (int i = 0; i < 3; i++) step_pulse(256);
    check_output("lock code 4", bus.io_out, 8'h0C);

    // Random runs of jittered valid intervals, stray invalid ones and a few stalls.
    longs = 0;
    for (int p = 0; p < 40; p++) begin
      code = int'($urandom_range(0, 4));
      run  = int'($urandom_range(1, 5));
      for (int r = 0; r < run; r++) begin
        kind = int'($urandom_range(0, 15));
        if (kind == 0) begin
          gap = int'($urandom_range(3, 300));
        end else if (kind == 1 && longs < 3) begin
          gap = int'($urandom_range(2040, 2200));
          longs++;
        end else begin
          gap = (1 << (BASE + code)) + int'($urandom_range(0, 2)) - 1;
        end
        step_pulse(gap);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
